me_sad_row_accum: RTL



---
 rtl/me_pkg.sv | 29 ++
 rtl/me_sad16_row.sv | 37 +++
 rtl/me_sad_row_accum.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared widths, FSM states and pipeline tag for the SAD row accumulator
// No ports; imported by me_sad16_row and me_sad_row_accum.
package me_pkg;

  localparam int PIX_W       = 8;
  localparam int PIX_PER_ROW = 16;
  localparam int ROW_SAD_W   = 12;
  localparam int SAD_W       = 16;
  // Tag fields are sized for the widest legal search (NUM_CAND <= 63).
  localparam int CAND_W      = 6;
  // Several bits so a burst of restarts cannot alias a stale beat onto the live search id.
  localparam int SID_W       = 3;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  typedef struct packed {
    logic              valid;
    logic              first;
    logic              last;
    logic [CAND_W-1:0] cand;
    logic [SID_W-1:0]  sid;
  } tag_t;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/me_sad16_row.sv
// rtl/me_sad16_row.sv - 16-lane absolute difference and row sum, two register stages
// Ports:
//   clk_i  clock
//   ref_i  16 reference pixels, pixel k at [8k+7:8k]
//   cur_i  16 current-block pixels, same byte order
//   sum_o  registered row SAD, valid two cycles after ref_i/cur_i
module me_sad16_row import me_pkg::*; (
  input  logic                         clk_i,
  input  logic [PIX_PER_ROW*PIX_W-1:0] ref_i,
  input  logic [PIX_PER_ROW*PIX_W-1:0] cur_i,
  output logic [ROW_SAD_W-1:0]         sum_o
);

  logic [PIX_W-1:0]     diff_q [PIX_PER_ROW];
  logic [ROW_SAD_W-1:0] sum_d, sum_q;

  // Pure datapath: qualification is done by the tags in the parent.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < PIX_PER_ROW; k++) begin
      diff_q[k] <= abs_diff(ref_i[k*PIX_W +: PIX_W], cur_i[k*PIX_W +: PIX_W]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < PIX_PER_ROW; k++) begin
      sum_d = sum_d + ROW_SAD_W'(diff_q[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/me_sad_row_accum.sv
// rtl/me_sad_row_accum.sv - per-candidate SAD accumulation and minimum-SAD tracking
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   start_i              pulse: clear results and begin a search
//   valid_i              ref_win_i/cur_row_i carry one row beat
//   ref_win_i/cur_row_i  16 pixels each, pixel k at [8k+7:8k]
//   busy_o               search in progress
//   done_o               one-cycle pulse, best outputs final
//   best_sad_o/best_idx_o minimum candidate SAD and its index
//   prune_o/prune_cnt_o  only with ME_SAD_PRUNE_STATS_EN: prune hint and per-search count
module me_sad_row_accum import me_pkg::*; #(
  parameter int NUM_CAND = 33,
  parameter int ROWS     = 16,
  parameter int IDX_W    = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic [127:0]     ref_win_i,
  input  logic [127:0]     cur_row_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      best_sad_o,
  output logic [IDX_W-1:0] best_idx_o
`ifdef ME_SAD_PRUNE_STATS_EN
  ,
  output logic             prune_o,
  output logic [IDX_W-1:0] prune_cnt_o
`endif
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [CAND_W-1:0] CAND_LAST = CAND_W'(NUM_CAND - 1);

  state_e               state_q, state_d;
  logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
  logic [CAND_W-1:0]    cand_cnt_q, cand_cnt_d;
  logic [SID_W-1:0]     sid_q, sid_d;
  tag_t                 tag1_d, tag1_q, tag2_q, tag3_q;
  logic [SAD_W-1:0]     acc_d, acc_q;
  logic [SAD_W-1:0]     best_sad_d, best_sad_q;
  logic [IDX_W-1:0]     best_idx_d, best_idx_q;
  logic                 best_valid_d, best_valid_q;
  logic [ROW_SAD_W-1:0] row_sum;
  logic                 accept, tag2_live, tag3_live, upd_best;

  me_sad16_row u_row (
    .clk_i (clk_i),
    .ref_i (ref_win_i),
    .cur_i (cur_row_i),
    .sum_o (row_sum)
  );

  // A beat in the start cycle belongs to no search and is ignored.
  assign accept    = (state_q == RUN) && valid_i && !start_i;
  // Beats launched before the latest start carry an old search id and are dropped.
  assign tag2_live = tag2_q.valid && (tag2_q.sid == sid_q);
  assign tag3_live = tag3_q.valid && (tag3_q.sid == sid_q);

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    cand_cnt_d   = cand_cnt_q;
    sid_d        = sid_q;
    tag1_d       = '0;
    tag1_d.valid = accept;
    tag1_d.first = (row_cnt_q == '0);
    tag1_d.last  = (row_cnt_q == ROW_LAST);
    tag1_d.cand  = cand_cnt_q;
    tag1_d.sid   = sid_q;
    if (start_i) begin
      state_d    = RUN;
      row_cnt_d  = '0;
      cand_cnt_d = '0;
      sid_d      = sid_q + 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          if (accept) begin
            if (row_cnt_q == ROW_LAST) begin
              row_cnt_d  = '0;
              cand_cnt_d = cand_cnt_q + 1'b1;
              if (cand_cnt_q == CAND_LAST) state_d = FLUSH;
            end else begin
              row_cnt_d = row_cnt_q + 1'b1;
            end
          end
        end
        FLUSH: if (!(tag1_q.valid || tag2_q.valid || tag3_q.valid)) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (tag2_live) acc_d = tag2_q.first ? SAD_W'(row_sum) : acc_q + SAD_W'(row_sum);

    // Strict less-than keeps the lower index on ties.
    upd_best     = tag3_live && tag3_q.last && (!best_valid_q || (acc_q < best_sad_q));
    best_sad_d   = best_sad_q;
    best_idx_d   = best_idx_q;
    best_valid_d = best_valid_q;
    if (start_i) begin
      best_sad_d   = '0;
      best_idx_d   = '0;
      best_valid_d = 1'b0;
    end else if (upd_best) begin
      best_sad_d   = acc_q;
      best_idx_d   = IDX_W'(tag3_q.cand);
      best_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      row_cnt_q    <= '0;
      cand_cnt_q   <= '0;
      sid_q        <= '0;
      tag1_q       <= '0;
      tag2_q       <= '0;
      tag3_q       <= '0;
      acc_q        <= '0;
      best_sad_q   <= '0;
      best_idx_q   <= '0;
      best_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      cand_cnt_q   <= cand_cnt_d;
      sid_q        <= sid_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag1_q;
      tag3_q       <= tag2_q;
      acc_q        <= acc_d;
      best_sad_q   <= best_sad_d;
      best_idx_q   <= best_idx_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign busy_o     = (state_q == RUN) || (state_q == FLUSH);
  assign done_o     = (state_q == DONE);
  assign best_sad_o = best_sad_q;
  assign best_idx_o = best_idx_q;

`ifdef ME_SAD_PRUNE_STATS_EN
  logic             pruned_q, pruned_d, cur_pruned, prune;
  logic [IDX_W-1:0] prune_cnt_q, prune_cnt_d;

  // The candidate-already-pruned flag is forgotten when the next candidate's first row arrives.
  always_comb begin
    cur_pruned  = pruned_q && !tag3_q.first;
    prune       = tag3_live && !tag3_q.last && best_valid_q && (acc_q >= best_sad_q) && !cur_pruned;
    pruned_d    = tag3_live ? (cur_pruned || prune) : pruned_q;
    prune_cnt_d = start_i ? '0 : prune_cnt_q + IDX_W'(prune);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pruned_q    <= 1'b0;
      prune_cnt_q <= '0;
    end else begin
      pruned_q    <= start_i ? 1'b0 : pruned_d;
      prune_cnt_q <= prune_cnt_d;
    end
  end

  assign prune_o     = prune;
  assign prune_cnt_o = prune_cnt_q;
`else
  // The first-row tag at the compare stage is only consumed by the prune logic.
  logic unused_first;
  assign unused_first = tag3_q.first;
`endif

endmodule
